adc_capture_buffer: RTL

//  Snapshot buffer on one RFDC ADC AXI4-Stream (128b = 8 x 16b samples/beat, aclk domain), in parallel

---
 rtl/adc_capture_buffer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_capture_buffer.sv
// Purpose: circular snapshot buffer on one ADC AXI4-Stream with programmable pretrigger depth.
// Latency: rd_data is mem[rd_addr] one aclk later; status and trigger addresses update on the clock edge.
// Backpressure: never back-pressures; s_axis_tready is low only while reset is asserted.
//
// Ports:
//   aclk, reset      stream clock, async active-high reset
//   s_axis_*         ADC beat in (NSAMP x SAMPLE_BITS signed samples), tready
//   arm              pulse: start or restart a capture
//   sw_trig          pulse: software trigger
//   sysref_trig      level: a rising edge is a trigger
//   trig_sel         0 sw, 1 sysref, 2 threshold, 3 any
//   pretrig          words kept before the trigger beat (clamped to DEPTH-1)
//   threshold        unsigned magnitude limit (only when THRESH_TRIG_EN is defined)
//   rd_addr/rd_data  synchronous read-first read port
//   busy, done       capture in progress / capture complete
//   trig_addr        address of the trigger beat
//   start_addr       address of the oldest captured word
// Build option: define THRESH_TRIG_EN to add the threshold port and comparator.
module adc_capture_buffer #(
   parameter int DEPTH_LOG2  = 10,
   parameter int NSAMP       = 8,
   parameter int SAMPLE_BITS = 16
) (
   input  logic                           aclk,
   input  logic                           reset,
   input  logic [NSAMP*SAMPLE_BITS-1:0]   s_axis_tdata,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           arm,
   input  logic                           sw_trig,
   input  logic                           sysref_trig,
   input  logic [1:0]                     trig_sel,
   input  logic [DEPTH_LOG2:0]            pretrig,
`ifdef THRESH_TRIG_EN
   input  logic [SAMPLE_BITS-1:0]         threshold,
`endif
   input  logic [DEPTH_LOG2-1:0]          rd_addr,
   output logic [NSAMP*SAMPLE_BITS-1:0]   rd_data,
   output logic                           busy,
   output logic                           done,
   output logic [DEPTH_LOG2-1:0]          trig_addr,
   output logic [DEPTH_LOG2-1:0]          start_addr
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int W     = NSAMP*SAMPLE_BITS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ARMED,
      S_POST,
      S_DONE
   } state_t;

   state_t                 state, state_nxt;
   logic [DEPTH_LOG2-1:0]  wptr;
   logic [DEPTH_LOG2-1:0]  fill_cnt;
   logic [DEPTH_LOG2-1:0]  post_cnt;
   logic [DEPTH_LOG2-1:0]  pre_eff;
   logic [DEPTH_LOG2-1:0]  pretrig_clamp;
   logic                   trig_pend;
   logic                   sysref_prev;
   logic                   sysref_rise;
   logic                   thr_hit;
   logic                   trig_ev;
   logic                   wr_en;
   logic                   trig_beat;

   logic [W-1:0]           mem [DEPTH];

   assign s_axis_tready = ~reset;

   // pretrig >= DEPTH exactly when its top bit is set, so clamp on that bit.
   assign pretrig_clamp = pretrig[DEPTH_LOG2] ? '1 : pretrig[DEPTH_LOG2-1:0];
   assign sysref_rise   = sysref_trig & ~sysref_prev;

`ifdef THRESH_TRIG_EN
   // Magnitude is formed one bit wider so that the most negative sample maps to +2**(SAMPLE_BITS-1).
   always_comb begin
      logic [SAMPLE_BITS:0] ext;
      logic [SAMPLE_BITS:0] mag;
      thr_hit = 1'b0;
      ext     = '0;
      mag     = '0;
      for (int i = 0; i < NSAMP; i++) begin
         ext = {s_axis_tdata[i*SAMPLE_BITS+SAMPLE_BITS-1], s_axis_tdata[i*SAMPLE_BITS +: SAMPLE_BITS]};
         mag = ext[SAMPLE_BITS] ? (~ext + 1'b1) : ext;
         if (s_axis_tvalid && (mag > {1'b0, threshold}))
            thr_hit = 1'b1;
      end
   end
`else
   assign thr_hit = 1'b0;
`endif

   always_comb begin
      trig_ev = 1'b0;
      case (trig_sel)
         2'd0:    trig_ev = sw_trig;
         2'd1:    trig_ev = sysref_rise;
         2'd2:    trig_ev = thr_hit;
         default: trig_ev = sw_trig | sysref_rise | thr_hit;
      endcase
   end

   // State register
   always_ff @(posedge aclk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next state, write strobe and status outputs
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      trig_beat = 1'b0;
      case (state)
         S_FILL: begin
            if (s_axis_tvalid) begin
               wr_en = 1'b1;
               if (fill_cnt + 1'b1 == pre_eff)
                  state_nxt = S_ARMED;
            end
         end
         S_ARMED: begin
            if (s_axis_tvalid) begin
               wr_en = 1'b1;
               if (trig_pend || trig_ev) begin
                  trig_beat = 1'b1;
                  state_nxt = (post_cnt == '0) ? S_DONE : S_POST;
               end
            end
         end
         S_POST: begin
            if (s_axis_tvalid) begin
               wr_en = 1'b1;
               if (post_cnt == DEPTH_LOG2'(1))
                  state_nxt = S_DONE;
            end
         end
         S_IDLE, S_DONE: begin
         end
         default: state_nxt = S_IDLE;
      endcase
      // arm overrides everything, including a trigger beat in the same cycle.
      if (arm) begin
         state_nxt = (pretrig_clamp == '0) ? S_ARMED : S_FILL;
         wr_en     = 1'b0;
         trig_beat = 1'b0;
      end
      busy = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
      done = (state == S_DONE);
   end

   // Pointers, counters and trigger bookkeeping
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         wptr        <= '0;
         fill_cnt    <= '0;
         post_cnt    <= '0;
         pre_eff     <= '0;
         trig_pend   <= 1'b0;
         sysref_prev <= 1'b0;
         trig_addr   <= '0;
         start_addr  <= '0;
      end else begin
         sysref_prev <= sysref_trig;
         if (arm) begin
            wptr      <= '0;
            fill_cnt  <= '0;
            pre_eff   <= pretrig_clamp;
            post_cnt  <= ~pretrig_clamp;   // DEPTH-1 - pretrig_eff
            trig_pend <= 1'b0;
         end else begin
            if (wr_en)
               wptr <= wptr + 1'b1;
            if (state == S_FILL) begin
               trig_pend <= 1'b0;
               if (wr_en)
                  fill_cnt <= fill_cnt + 1'b1;
            end
            if (state == S_ARMED) begin
               if (trig_beat) begin
                  trig_pend  <= 1'b0;
                  trig_addr  <= wptr;
                  start_addr <= wptr - pre_eff;
               end else if (trig_ev) begin
                  // Event with no beat this cycle: the next valid beat becomes the trigger beat.
                  trig_pend <= 1'b1;
               end
            end
            if ((state == S_POST) && wr_en)
               post_cnt <= post_cnt - 1'b1;
         end
      end
   end

   // Capture memory, no reset so it maps onto block RAM
   always_ff @(posedge aclk) begin
      if (wr_en)
         mem[wptr] <= s_axis_tdata;
   end

   // Read-first port: a read of the address being written returns the previous word.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset)
         rd_data <= '0;
      else
         rd_data <= mem[rd_addr];
   end

endmodule
